wb_cmd_master: RTL

//  Wishbone classic (B4, non-pipelined) bus initiator for the user project area; the master-side counterpart of the wrapper_* responders.

---
 rtl/wb_cmd_master_if.sv | 42 ++++
 rtl/wb_cmd_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone master signals of wb_cmd_master, grouped as one bundle.
// The master modport is the initiator's view; the slave modport is the view of whoever sits on the other side.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  rsp_ready,
    input  wbm_dat_i, wbm_ack_i,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output rsp_ready,
    output wbm_dat_i, wbm_ack_i,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one read or write cycle; min 2 cycles accept-to-response.
// One transaction outstanding; cmd_ready stays low until the response is consumed, and the response holds while rsp_ready is low.
module wb_cmd_master #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_cmd_master_if.master bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q,     state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cyc_q,       cyc_d;
  req_t             req_q,       req_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q,   rsp_dat_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        // cmd_ready comes up one cycle after reset release, then stays up while idle
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          req_d.we    = bus.cmd_we;
          req_d.adr   = bus.cmd_adr;
          req_d.dat   = bus.cmd_dat;
          req_d.sel   = bus.cmd_sel;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_BUS;
        end
      end

      S_BUS: begin
        // ack is checked before the timeout so a boundary-cycle ack still completes
        if (bus.wbm_ack_i) begin
          cyc_d       = 1'b0;
          req_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = req_q.we ? 32'd0 : bus.wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          req_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'd0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = 32'd0;
          rsp_err_d   = 1'b0;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        cyc_d       = 1'b0;
        req_d       = '0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = req_q.we;
  assign bus.wbm_adr_o = req_q.adr;
  assign bus.wbm_dat_o = req_q.dat;
  assign bus.wbm_sel_o = req_q.sel;
  assign busy          = busy_q;

endmodule
